// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage and its pipeline registers.
package fetch_unit_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned INST_W = 32;

    typedef logic [ADDR_W-1:0] pc_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam inst_t HALT_WORD = 32'h0000_0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    // Word-address increment; wraps modulo 2^ADDR_W.
    function automatic pc_t pc_next(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load, hold, or squash (clear valid, keep payload).
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_squash,
    input  logic [INST_W-1:0] i_inst,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_valid
);

    inst_t r_inst;
    pc_t   r_pc;
    logic  r_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_inst  <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_squash) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_inst  <= i_inst;
            r_pc    <= i_pc;
            r_valid <= i_valid;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-address mux, in-flight tracking, sticky halt.
// Optional FETCH_BUBBLE_COUNT_EN adds a saturating 16-bit bubble counter output.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_inst,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              halted
`ifdef FETCH_BUBBLE_COUNT_EN
    ,
    output logic [15:0]       bubble_count
`endif
);

    fetch_state_t r_state;
    pc_t          r_pc;
    logic         r_inflight;

    pc_t  w_mem_addr;
    logic w_load;
    logic w_squash;
    logic w_halt_hit;

    // Priority: reset > halted > branch > stall > normal.
    always_comb begin
        w_mem_addr = r_pc;
        w_load     = 1'b0;
        w_squash   = 1'b0;
        w_halt_hit = 1'b0;
        if (reset) begin
            w_mem_addr = '0;
        end else if (r_state == FS_HALT) begin
            w_squash = 1'b1;
        end else if (branch_taken) begin
            w_mem_addr = branch_target;
            w_squash   = 1'b1;
        end else if (!stall) begin
            w_mem_addr = pc_next(r_pc);
            w_load     = 1'b1;
            w_halt_hit = r_inflight && (mem_inst == HALT_WORD);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= FS_RUN;
            r_pc       <= '0;
            r_inflight <= 1'b1;
        end else if (r_state == FS_RUN) begin
            if (branch_taken) begin
                r_pc       <= branch_target;
                r_inflight <= 1'b1;
            end else if (w_load) begin
                r_pc <= pc_next(r_pc);
                if (w_halt_hit) begin
                    r_state <= FS_HALT;
                end
            end
        end
    end

    if_id_reg u_if_id (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_squash (w_squash),
        .i_inst   (mem_inst),
        .i_pc     (r_pc),
        .i_valid  (r_inflight),
        .o_inst   (if_inst),
        .o_pc     (if_pc),
        .o_valid  (if_valid)
    );

    assign mem_addr = w_mem_addr;
    assign halted   = (r_state == FS_HALT);

`ifdef FETCH_BUBBLE_COUNT_EN
    logic [15:0] r_bubble;
    logic        w_next_valid;

    // Mirrors the IF/ID valid update so the count reflects if_valid after the edge.
    always_comb begin
        w_next_valid = if_valid;
        if (w_squash) begin
            w_next_valid = 1'b0;
        end else if (w_load) begin
            w_next_valid = r_inflight;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bubble <= '0;
        end else if ((r_state == FS_RUN) && !w_next_valid && (r_bubble != '1)) begin
            r_bubble <= r_bubble + 16'd1;
        end
    end

    assign bubble_count = r_bubble;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector tables, directed corner sequences, random vs stream model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic  clock;
    logic  reset;
    logic  stall;
    logic  branch_taken;
    pc_t   branch_target;
    pc_t   mem_addr;
    inst_t mem_inst;
    inst_t if_inst;
    pc_t   if_pc;
    logic  if_valid;
    logic  halted;
`ifdef FETCH_BUBBLE_COUNT_EN
    logic [15:0] bubble_count;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] mem [0:2047];

    fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_addr      (mem_addr),
        .mem_inst      (mem_inst),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .halted        (halted)
`ifdef FETCH_BUBBLE_COUNT_EN
        ,
        .bubble_count  (bubble_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One-cycle synchronous-read instruction memory.
    always @(posedge clock) mem_inst <= mem[mem_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        st;
        logic        br;
        pc_t         tgt;
        pc_t         e_addr;
        logic        e_valid;
        pc_t         e_pc;
        logic [31:0] e_inst;
        logic        e_halted;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic br, input int tgt,
                                input int e_addr, input logic e_valid, input int e_pc,
                                input logic [31:0] e_inst, input logic e_halted);
        vec_t v;
        v.rst = rst; v.st = st; v.br = br; v.tgt = pc_t'(tgt);
        v.e_addr = pc_t'(e_addr); v.e_valid = e_valid; v.e_pc = pc_t'(e_pc);
        v.e_inst = e_inst; v.e_halted = e_halted;
        return v;
    endfunction

    function automatic logic [31:0] F(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input pc_t t);
        reset = r; stall = s; branch_taken = b; branch_target = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_table(input string tag, input vec_t tv[$]);
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].st, tv[i].br, tv[i].tgt);
            chk($sformatf("%s[%0d] mem_addr", tag, i), 32'(mem_addr), 32'(tv[i].e_addr));
            tick();
            chk($sformatf("%s[%0d] if_valid", tag, i), 32'(if_valid), 32'(tv[i].e_valid));
            chk($sformatf("%s[%0d] if_pc", tag, i), 32'(if_pc), 32'(tv[i].e_pc));
            chk($sformatf("%s[%0d] if_inst", tag, i), if_inst, tv[i].e_inst);
            chk($sformatf("%s[%0d] halted", tag, i), 32'(halted), 32'(tv[i].e_halted));
        end
    endtask

    localparam logic [31:0] WA = 32'hA0A0_0001;
    localparam logic [31:0] WB = 32'hB0B0_0002;
    localparam logic [31:0] WC = 32'hC0C0_0003;

    initial begin
        vec_t t1[$];
        vec_t t2[$];
        int   m_next;
        logic m_valid;
        int   m_pc;
        logic [31:0] m_inst;
        logic m_halted;
        int   m_bub;
        int   e_addr;
`ifdef FETCH_BUBBLE_COUNT_EN
        int   b0;
`endif

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        for (int i = 0; i < 2048; i++) mem[i] = F(i);
        mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = 32'h0;

        // Sequential run into halt, halted ignores branch/stall, reset clears halt.
        t1.push_back(mk(1,0,0,0,   0, 0,0,0,  0));
        t1.push_back(mk(1,0,0,0,   0, 0,0,0,  0));
        t1.push_back(mk(0,0,0,0,   1, 1,0,WA, 0));
        t1.push_back(mk(0,0,0,0,   2, 1,1,WB, 0));
        t1.push_back(mk(0,0,0,0,   3, 1,2,WC, 0));
        t1.push_back(mk(0,0,0,0,   4, 1,3,0,  1));
        t1.push_back(mk(0,0,0,0,   4, 0,3,0,  1));
        t1.push_back(mk(0,1,1,100, 4, 0,3,0,  1));
        t1.push_back(mk(0,0,0,0,   4, 0,3,0,  1));
        t1.push_back(mk(1,0,0,0,   0, 0,0,0,  0));
        t1.push_back(mk(0,0,0,0,   1, 1,0,WA, 0));
        run_table("seq_halt", t1);

        for (int i = 0; i < 4; i++) mem[i] = F(i);

        // Stall hold, branch bubble, branch beats stall, stall during bubble.
        t2.push_back(mk(1,0,0,0,   0,   0,0,0,       0));
        t2.push_back(mk(0,0,0,0,   1,   1,0,F(0),    0));
        t2.push_back(mk(0,0,0,0,   2,   1,1,F(1),    0));
        t2.push_back(mk(0,1,0,0,   2,   1,1,F(1),    0));
        t2.push_back(mk(0,1,0,0,   2,   1,1,F(1),    0));
        t2.push_back(mk(0,1,0,0,   2,   1,1,F(1),    0));
        t2.push_back(mk(0,0,0,0,   3,   1,2,F(2),    0));
        t2.push_back(mk(1,0,0,0,   0,   0,0,0,       0));
        t2.push_back(mk(0,0,0,0,   1,   1,0,F(0),    0));
        t2.push_back(mk(0,0,0,0,   2,   1,1,F(1),    0));
        t2.push_back(mk(0,0,1,100, 100, 0,1,F(1),    0));
        t2.push_back(mk(0,0,0,0,   101, 1,100,F(100),0));
        t2.push_back(mk(0,0,0,0,   102, 1,101,F(101),0));
        t2.push_back(mk(0,1,1,50,  50,  0,101,F(101),0));
        t2.push_back(mk(0,0,0,0,   51,  1,50,F(50),  0));
        t2.push_back(mk(0,0,0,0,   52,  1,51,F(51),  0));
        t2.push_back(mk(0,0,1,10,  10,  0,51,F(51),  0));
        t2.push_back(mk(0,1,0,0,   10,  0,51,F(51),  0));
        t2.push_back(mk(0,0,0,0,   11,  1,10,F(10),  0));
        run_table("stall_branch", t2);

        // Branch near top of address space: PC wraps 2047 -> 0.
        drive(1,0,0,0); tick();
        drive(0,0,0,0); tick();
        drive(0,0,1,pc_t'(2046));
        chk("wrap mem_addr br", 32'(mem_addr), 32'd2046);
        tick();
        chk("wrap bubble valid", 32'(if_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            int exp_pc;
            exp_pc = (2046 + k) % 2048;
            drive(0,0,0,0);
            chk($sformatf("wrap mem_addr %0d", k), 32'(mem_addr), 32'((exp_pc + 1) % 2048));
            tick();
            chk($sformatf("wrap if_pc %0d", k), 32'(if_pc), 32'(exp_pc));
            chk($sformatf("wrap if_inst %0d", k), if_inst, F(exp_pc));
            chk($sformatf("wrap if_valid %0d", k), 32'(if_valid), 32'd1);
        end

        // Reset mid-stream at if_pc=7.
        drive(1,0,0,0); tick();
        for (int k = 0; k < 8; k++) begin
            drive(0,0,0,0); tick();
        end
        chk("midrst pre pc", 32'(if_pc), 32'd7);
        drive(1,0,0,0);
        chk("midrst mem_addr", 32'(mem_addr), 32'd0);
        tick();
        chk("midrst valid", 32'(if_valid), 32'd0);
        chk("midrst halted", 32'(halted), 32'd0);
        chk("midrst mem_addr held", 32'(mem_addr), 32'd0);
`ifdef FETCH_BUBBLE_COUNT_EN
        chk("midrst bubble_count", 32'(bubble_count), 32'd0);
`endif
        drive(0,0,0,0); tick();
        chk("midrst first pc", 32'(if_pc), 32'd0);
        chk("midrst first valid", 32'(if_valid), 32'd1);
`ifdef FETCH_BUBBLE_COUNT_EN
        b0 = int'(bubble_count);
        drive(0,0,1,pc_t'(100)); tick();
        drive(0,0,0,0); tick();
        chk("branch bubble_count +1", 32'(bubble_count), 32'(b0 + 1));
        chk("branch then pc", 32'(if_pc), 32'd100);
`endif

        // Random stimulus against an instruction-stream model.
        for (int i = 0; i < 2048; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (w == 32'h0) w = 32'h1;
            if ($urandom_range(0, 49) == 0) w = 32'h0;
            mem[i] = w;
        end
        m_next = 0; m_valid = 1'b0; m_pc = 0; m_inst = '0; m_halted = 1'b0; m_bub = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r, s, b;
            int   t;
            r = (c == 0) || ($urandom_range(0, 99) < (m_halted ? 15 : 1));
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 3) == 0) ? 2044 + $urandom_range(0, 3) : $urandom_range(0, 2047);

            if (r)             e_addr = 0;
            else if (m_halted) e_addr = m_next;
            else if (b)        e_addr = t;
            else if (s)        e_addr = m_next;
            else               e_addr = (m_next + 1) % 2048;

            drive(r, s, b, pc_t'(t));
            chk($sformatf("rnd[%0d] mem_addr", c), 32'(mem_addr), 32'(e_addr));
            tick();

            if (r) begin
                m_next = 0; m_valid = 1'b0; m_pc = 0; m_inst = '0; m_halted = 1'b0; m_bub = 0;
            end else if (m_halted) begin
                m_valid = 1'b0;
            end else if (b) begin
                m_valid = 1'b0;
                m_next  = t;
                if (m_bub < 65535) m_bub++;
            end else if (s) begin
                if (!m_valid && m_bub < 65535) m_bub++;
            end else begin
                m_pc    = m_next;
                m_inst  = mem[m_next];
                m_valid = 1'b1;
                if (m_inst == 32'h0) m_halted = 1'b1;
                m_next  = (m_next + 1) % 2048;
            end

            chk($sformatf("rnd[%0d] if_valid", c), 32'(if_valid), 32'(m_valid));
            chk($sformatf("rnd[%0d] if_pc", c), 32'(if_pc), 32'(m_pc));
            chk($sformatf("rnd[%0d] if_inst", c), if_inst, m_inst);
            chk($sformatf("rnd[%0d] halted", c), 32'(halted), 32'(m_halted));
`ifdef FETCH_BUBBLE_COUNT_EN
            chk($sformatf("rnd[%0d] bubble_count", c), 32'(bubble_count), 32'(m_bub));
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the 2048x32 instruction memory, which has a one-cycle synchronous read. Generates the word address each cycle, tracks the in-flight read, and captures the returned word plus its PC into an IF/ID output register for decode. Handles stall from hazard detection, branch redirect from execute, and a sticky halt on the all-zero instruction word.

Parameters:
ADDR_W, 11, instruction-memory word-address width; PC increments by 1 per word.
INST_W, 32, instruction width.
HALT_WORD, 32'h0000_0000, encoding that stops fetch.

Ports:
clock  input  1  single clock, all state on posedge
reset  input  1  synchronous, active-high; sampled on posedge clock
stall  input  1  hazard unit: hold IF/ID contents and re-read current address
branch_taken  input  1  redirect fetch this cycle
branch_target  input  ADDR_W  redirect address
mem_addr  output  ADDR_W  combinational address to instruction memory
mem_inst  input  INST_W  memory read data, valid one cycle after mem_addr
if_inst  output  INST_W  registered instruction to decode
if_pc  output  ADDR_W  registered address of if_inst
if_valid  output  1  if_inst/if_pc hold a real instruction
halted  output  1  sticky; halt word has been issued

Behaviour:
- State: pc_q (address whose data is on mem_inst this cycle), inflight_q (that data is usable), if_inst/if_pc/if_valid, halted.
- Reset (takes effect on the clock edge): pc_q=0, inflight_q=1, if_inst=0, if_pc=0, if_valid=0, halted=0. mem_addr=0 while reset is high, so mem[0] is on mem_inst in the first cycle after reset.
- Evaluation order per cycle: reset > halted > branch_taken > stall > normal.
- Halted: mem_addr=pc_q; all registers hold; if_valid=0 after the halt word's issue cycle. branch_taken and stall are ignored. Only reset clears halted.
- Branch: mem_addr=branch_target; pc_q<=branch_target; inflight_q<=1; if_valid<=0 (the word on mem_inst is squashed); if_inst/if_pc hold. Branch wins over a simultaneous stall.
- Stall: mem_addr=pc_q, which re-reads the same word, so nothing is lost; all registers hold.
- Normal: if_inst<=mem_inst; if_pc<=pc_q; if_valid<=inflight_q; mem_addr=pc_q+1; pc_q<=pc_q+1.
- Halt detection: in the normal case, if inflight_q=1 and mem_inst==HALT_WORD, the word is issued with if_valid=1 and halted<=1 in the same edge.
- Arithmetic: pc_q+1 is modulo 2^ADDR_W, so 2047 wraps to 0 without a flag.
- Latency: mem_addr=A at cycle n gives if_pc=A at cycle n+2. Sequential throughput is 1 instruction/cycle. A taken branch costs exactly 1 bubble.
- Reset asserted mid-stream overrides everything; the first post-reset output is if_pc=0.

Optional Feature:
FETCH_BUBBLE_COUNT_EN. When defined, adds output bubble_count (16 bits):
- Reset to 0.
- Increments on each clock with reset=0, halted=0 and if_valid=0 after the update (branch squash, reset drain).
- Stall cycles holding a valid word are not counted.
- Saturates at 16'hFFFF.
When undefined, the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: ADDR_W, INST_W, HALT_WORD constants, plus a pc_t typedef (ADDR_W bits) reused by decode and branch logic.
- One sub-module is natural: if_id_reg, the load/hold/squash register for inst, pc and valid, reusable for later pipeline registers.
- Next-address mux and halt logic stay in fetch_unit.

Test Plan:
1. Reset, then run memory {0:A,1:B,2:C,3:0} -> if_pc/if_inst = 0/A, 1/B, 2/C, 3/0 with if_valid=1 on consecutive cycles; halted=1 after PC 3; mem_addr stays 4 thereafter; if_valid=0.
2. Stall high 3 cycles while if_pc=1 -> if_pc=1 and if_inst=B held for 3 cycles; next cycle if_pc=2 with no skipped or duplicated word.
3. branch_taken with branch_target=100 while if_pc=1 -> next cycle if_valid=0; following cycle if_pc=100 with if_valid=1, then 101.
4. branch_taken and stall both high, target=50 -> branch wins; if_pc=50 two cycles later.
5. Branch target 2046 with nonzero memory -> if_pc sequence 2046, 2047, 0, 1.
6. Assert reset mid-stream at if_pc=7 -> next cycle if_valid=0, halted=0, mem_addr=0; then if_pc=0. With FETCH_BUBBLE_COUNT_EN, scenario 3 leaves bubble_count incremented by exactly 1.
